// File: rtl/setbit_pkg.sv
// Shared types and constants for the setbit arbiter slice.
package setbit_pkg;

  localparam int W_DEF    = 4;
  localparam int STATUS_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select: search starts one past the previous grant.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  logic found;

  // Walk offsets 1..NREQ from last_grant and take the first asserted request.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found && req[k] && (k == ((int'(last_grant) + off) % NREQ))) begin
          found  = 1'b1;
          gnt[k] = 1'b1;
          idx    = IDW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/setbit.sv
// Combinational setbit datapath: set bit i_argB of i_argA when the index is in range.
// Status bits: [0] index out of range, [1] bit was already set,
//              [2] result is zero, [3] result is all ones.
module setbit
  import setbit_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0]        i_argA,
  input  logic [W-1:0]        i_argB,
  output logic [W-1:0]        o_result,
  output logic [STATUS_W-1:0] o_status
);

  logic         in_range;
  logic [W-1:0] mask;
  logic         already;

  // Build the single-bit mask and derive result and flags.
  always_comb begin
    in_range = (i_argB < W'(W));
    mask     = in_range ? ({{(W-1){1'b0}}, 1'b1} << i_argB) : '0;
    already  = |(i_argA & mask);
    o_result = i_argA | mask;
    o_status = {&o_result, ~|o_result, already, ~in_range};
  end

endmodule

// File: rtl/setbit_arb.sv
// Round-robin scheduler sharing one setbit datapath between NREQ requesters.
// state | meaning
// IDLE  | waiting for a request; ready is the round-robin one-hot grant
// EXEC  | captured operands drive setbit; result registered at cycle end
// RESP  | response valid and held until the consumer accepts it
module setbit_arb
  import setbit_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NREQ-1:0]     i_req_valid,
  input  logic [NREQ*W-1:0]   i_req_argA,
  input  logic [NREQ*W-1:0]   i_req_argB,
  output logic [NREQ-1:0]     o_req_ready,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [W-1:0]        o_rsp_result,
  output logic [STATUS_W-1:0] o_rsp_status,
  output logic [IDW-1:0]      o_rsp_id,
  output logic                o_busy
);

  state_t              state, state_nxt;
  logic [IDW-1:0]      last_grant;
  logic [NREQ-1:0]     win_gnt;
  logic [IDW-1:0]      win_idx;
  logic                accept;
  logic [W-1:0]        sel_a, sel_b;
  logic [W-1:0]        op_a, op_b;
  logic [IDW-1:0]      op_id;
  logic [W-1:0]        sb_result;
  logic [STATUS_W-1:0] sb_status;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req        (i_req_valid),
    .last_grant (last_grant),
    .gnt        (win_gnt),
    .idx        (win_idx)
  );

  setbit #(
    .W (W)
  ) u_setbit (
    .i_argA   (op_a),
    .i_argB   (op_b),
    .o_result (sb_result),
    .o_status (sb_status)
  );

  // Grants are only offered in IDLE and never while reset is asserted.
  assign o_req_ready = (state == IDLE && !i_rst) ? win_gnt : '0;
  assign accept      = |o_req_ready;
  assign o_busy      = (state != IDLE);
  assign o_rsp_valid = (state == RESP);

  // Select the winning requester's operand slices.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_gnt[k]) begin
        sel_a = i_req_argA[k*W +: W];
        sel_b = i_req_argB[k*W +: W];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (i_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, operand capture, grant pointer and response registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      last_grant   <= IDW'(NREQ - 1);
      op_a         <= '0;
      op_b         <= '0;
      op_id        <= '0;
      o_rsp_result <= '0;
      o_rsp_status <= '0;
      o_rsp_id     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && accept) begin
        op_a       <= sel_a;
        op_b       <= sel_b;
        op_id      <= win_idx;
        last_grant <= win_idx;
      end
      if (state == EXEC) begin
        o_rsp_result <= sb_result;
        o_rsp_status <= sb_status;
        o_rsp_id     <= op_id;
      end
    end
  end

endmodule

// File: doc/setbit_arb.md
Name: setbit_arb

Overview:
- Round-robin scheduler that shares one combinational setbit datapath instance between NREQ requesters.
- Each requester presents an operand pair (argA, argB) with a valid/ready handshake. The block grants one request, executes it on the shared setbit, and returns a registered result plus status, tagged with the requester ID, through a valid/ready response port.
- Sits between requester blocks and the setbit datapath.

Parameters:
- W, 4, operand/result width; must match setbit port width.
- NREQ, 2, number of requesters; legal range 2..4.
- IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  NREQ  per-requester request valid.
- i_req_argA  in  NREQ*W  packed operand A; requester k uses slice [k*W +: W].
- i_req_argB  in  NREQ*W  packed operand B (bit index); same packing.
- o_req_ready  out  NREQ  one-hot grant/accept; request k is accepted when valid[k] and ready[k] are both high.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response consumer ready.
- o_rsp_result  out  W  registered setbit o_result.
- o_rsp_status  out  4  registered setbit o_status.
- o_rsp_id  out  IDW  index of the requester that owns the response.
- o_busy  out  1  high whenever state != IDLE.

Behaviour:
- setbit contract:
  - o_result = argA with bit argB set, for argB < W.
  - argB >= W: o_result = argA unchanged.
  - o_status is passed through unmodified.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - o_req_ready is combinational and one-hot for the winner among asserted i_req_valid bits.
  - Winner is chosen round-robin, starting the search at (last_grant+1) mod NREQ.
  - If no valid is asserted, o_req_ready = 0.
  - On accept: capture argA, argB and ID into operand registers, update last_grant, go to EXEC.
- EXEC (exactly 1 cycle):
  - Operand registers drive the setbit instance.
  - At the end of the cycle, result, status and ID are registered into the response registers; go to RESP.
  - o_req_ready = 0.
- RESP:
  - o_rsp_valid = 1; result, status and ID are held stable until the handshake.
  - On i_rsp_ready = 1: go to IDLE.
  - o_req_ready = 0. There is no accept in the same cycle as the response handshake.
- Latency: accept in cycle t, o_rsp_valid first high in cycle t+2. Minimum of 3 cycles per operation.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 other grants.
- Stalled consumer: the block stays in RESP indefinitely; requesters see ready = 0 throughout.
- A requester dropping valid before it is granted: no effect, no state change.
- Reset values:
  - state = IDLE.
  - o_rsp_valid = 0, o_rsp_result = 0, o_rsp_status = 0, o_rsp_id = 0, o_busy = 0.
  - last_grant = NREQ-1, so requester 0 has first priority.
  - o_req_ready = 0 while i_rst is high.
- Reset mid-operation (EXEC or RESP): the in-flight operation and response are discarded with no handshake; IDLE is reached on the next cycle.
- Simultaneous valid from all requesters in IDLE: only the round-robin winner sees ready; the others hold their requests.

Decomposition:
- Shared package setbit_pkg:
  - state enum typedef (IDLE/EXEC/RESP).
  - Constants W_DEF = 4, STATUS_W = 4.
- Round-robin winner logic goes in sub-module rr_arbiter (NREQ-wide).
  - Inputs: request vector, last_grant.
  - Outputs: one-hot grant and encoded index.
- setbit is instantiated unchanged inside setbit_arb.

Test Plan:
- Single request: requester 0, A=0000, B=0010 -> ready[0] high in the same cycle; 2 cycles later o_rsp_valid=1, result=0100, id=0.
- Round robin: both requesters continuously valid, i_rsp_ready=1 -> grant order 0,1,0,1; each response appears 3 cycles after the previous one; id alternates.
- Back-pressure: i_rsp_ready=0 for 5 cycles with a response pending -> result, status and id stable for all 5 cycles; o_req_ready=0; single handshake when ready rises.
- Out-of-range index: A=0010, B=1101 -> result=0010; status equals a standalone setbit reference instance driven with the same inputs.
- Reset in RESP: assert i_rst for 1 cycle while o_rsp_valid=1 -> next cycle o_rsp_valid=0, o_busy=0; the next grant goes to requester 0.
- Random soak: 1000 random ops with random valid and ready -> every accepted op produces exactly one response with matching id, in order, and result equal to the reference model.
